// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO / launch sequencer.
//   tx_state_e        : launch FSM state encoding
//   WAIT_BUSY_TIMEOUT : cycles to wait for the transmitter to drop ready
//   TO_CNT_W          : width of the WAIT_BUSY timeout counter
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int unsigned WAIT_BUSY_TIMEOUT = 4;
  localparam int unsigned TO_CNT_W          = 3;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous circular FIFO with occupancy counter and sticky overflow.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   wr_en, wr_data   : push request and byte
//   rd_en            : pop request (ignored when empty)
//   rd_data          : byte at the read pointer (combinational from storage)
//   full, empty      : decoded from level
//   level            : occupancy 0..2**AW
//   overflow, clr_ovf: sticky dropped-push flag and its clear
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic w_push;
  logic w_pop;
  logic w_drop;

  assign full  = (r_level == DEPTH);
  assign empty = (r_level == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);
  assign w_drop = wr_en && !w_push;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign rd_data  = r_mem[r_rd_ptr];
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter over a
// start/data/ready handshake. Never starts a frame before the previous
// one has completed (or been given up on after a short timeout).
// Ports:
//   clk, rstn                : clock, asynchronous active-low reset
//   wr_en, wr_data           : producer push interface
//   full, empty, level       : FIFO status
//   overflow, clr_ovf        : sticky dropped-push flag and its clear
//   busy                     : FIFO non-empty or sequencer not idle
//   tx_start, tx_data        : to transmitter (start is a 1-cycle pulse)
//   tx_ready                 : from transmitter, 1 = idle
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [TO_CNT_W-1:0]   r_to_cnt;
  logic [TO_CNT_W-1:0]   w_to_cnt_nxt;
  logic                  r_tx_start;
  logic                  w_tx_start_nxt;
  logic [7:0]            r_tx_data;
  logic [7:0]            w_rd_data;
  logic                  w_pop;

  sync_fifo #(.AW(AW), .DW(8)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (w_pop),
    .rd_data  (w_rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_to_cnt_nxt   = r_to_cnt;
    w_tx_start_nxt = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!empty && tx_ready) begin
          w_pop          = 1'b1;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // If ready never drops the transmitter missed the start; the byte
        // is abandoned rather than retried.
        if (!tx_ready) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_to_cnt == TO_CNT_W'(WAIT_BUSY_TIMEOUT - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_tx_start <= w_tx_start_nxt;
      if (w_pop) r_tx_data <= w_rd_data;
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = !empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        clr_ovf;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  // Transmitter model: 0 = normal frame, 1 = ready stuck high, 2 = ready held low
  int   mode = 0;
  logic m_ready;
  int   m_cnt;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Ready drops one cycle after start is seen and returns 10 cycles later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end else if (tx_start && mode == 0) begin
      m_ready <= 1'b0;
      m_cnt   <= 10;
    end
  end

  assign tx_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'b1 : m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Scoreboard monitor: each launched byte must match the next queued byte.
  always @(negedge clk) begin
    if (tx_start) begin
      pulses++;
      chk("single_pulse", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
      end else begin
        chk("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_start <= tx_start;
  end

  task automatic push(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start(input int lim, input string tag);
    int n = 0;
    while (!tx_start && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, tx_start}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    rstn    = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single byte, launch latency
    push(8'h41, 1);
    chk("lat_start_early", {31'd0, tx_start}, 32'd0);
    chk("lat_level1", {27'd0, level}, 32'd1);
    @(negedge clk);
    chk("lat_start", {31'd0, tx_start}, 32'd1);
    chk("lat_data", {24'd0, tx_data}, 32'h41);
    chk("lat_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    chk("start_dropped", {31'd0, tx_start}, 32'd0);
    wait_idle(200, "idle1");
    chk("pulses1", pulses, 32'd1);
    chk("data_hold", {24'd0, tx_data}, 32'h41);

    // Three bytes queued while transmitter busy, then drained
    mode = 2;
    push(8'h01, 1);
    chk("lvl_a", {27'd0, level}, 32'd1);
    push(8'h02, 1);
    chk("lvl_b", {27'd0, level}, 32'd2);
    push(8'h03, 1);
    chk("lvl_c", {27'd0, level}, 32'd3);
    mode = 0;
    wait_start(20, "start3");
    chk("lvl_dec", {27'd0, level}, 32'd2);
    @(negedge clk);
    wait_idle(300, "idle3");
    chk("pulses3", pulses, 32'd4);
    chk("q3", exp_q.size(), 32'd0);

    // Fill to full, drop one with simultaneous clear, then clear
    mode = 2;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1);
    chk("full16", {31'd0, full}, 32'd1);
    chk("lvl16", {27'd0, level}, 32'd16);
    chk("ovf_pre", {31'd0, overflow}, 32'd0);
    wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_prio", {31'd0, overflow}, 32'd1);
    chk("lvl_drop", {27'd0, level}, 32'd16);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Push while full in the same cycle as a pop
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    mode = 0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pp_start", {31'd0, tx_start}, 32'd1);
    chk("pp_level", {27'd0, level}, 32'd16);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    wait_idle(2000, "idle_full");
    chk("pulses_full", pulses, 32'd21);
    chk("q_full", exp_q.size(), 32'd0);
    chk("lvl_drained", {27'd0, level}, 32'd0);

    // Transmitter misses start: timeout then next byte, no relaunch
    mode = 1;
    push(8'h77, 1);
    push(8'h78, 1);
    wait_start(10, "stuck_a");
    t0 = cyc;
    @(negedge clk);
    wait_start(20, "stuck_b");
    t1 = cyc;
    chk("stuck_gap", t1 - t0, 32'd6);
    @(negedge clk);
    wait_idle(100, "idle_stuck");
    repeat (20) @(negedge clk);
    chk("pulses_stuck", pulses, 32'd23);
    chk("q_stuck", exp_q.size(), 32'd0);

    // Reset mid-frame with 5 bytes queued
    mode = 0;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1);
    chk("mid_level", {27'd0, level}, 32'd5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_empty", {31'd0, empty}, 32'd1);
    chk("ar_level", {27'd0, level}, 32'd0);
    chk("ar_start", {31'd0, tx_start}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_quiet", pulses, 32'd24);
    push(8'h99, 1);
    wait_idle(100, "idle_post");
    chk("post_rst_pulse", pulses, 32'd25);
    chk("post_rst_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
